// File: rtl/size_deconvert_pkg.sv
// Shared definitions for the byte-to-word deconverter and its sibling
// size_convert: FSM state encoding, LANES legality rule and the lane
// counter width helper.
package size_deconvert_pkg;

  // FSM state encoding (one bit, legacy-compatible constants)
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  // Only 1, 2 or 4 lanes per word are supported
  function automatic bit lanes_legal(input int unsigned lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

  // Lane counter width; a 1-lane build still keeps a 1-bit counter
  function automatic int unsigned cnt_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/deconvert_out_reg.sv
// Single-entry output holding register with valid/ready handshake.
// A completed word loads when the register is empty or is being drained in
// the same cycle; otherwise the new word is dropped and overflow pulses for
// one cycle. data keeps its last value when valid is low.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   load, word       - completed word strobe and value
//   ready            - downstream accept
//   data, valid      - held word and its qualifier
//   overflow         - one-cycle pulse: completed word dropped
module deconvert_out_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] word,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         overflow
);

  logic accept;

  // Room for a new word: empty, or the held word leaves this cycle
  assign accept = !valid || ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      data     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= load && !accept;
      if (load && accept) begin
        data  <= word;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/size_deconvert.sv
// Byte stream to word assembler. Bytes arriving with VALID_IN are packed
// LSB-first into an assembly buffer; each complete word is handed to a
// separate output register so assembly continues while a word waits.
// A gap in VALID_IN mid-word discards the partial word (ERR_PARTIAL).
// Ports:
//   PCLK, RESET          - clock, synchronous active-high reset
//   DATA_IN, VALID_IN    - incoming byte and qualifier (no backpressure)
//   DATA_OUT, VALID_OUT  - assembled word and qualifier
//   READY_IN             - downstream accepts word when VALID_OUT & READY_IN
//   IDLE_OUT             - FSM in IDLE
//   ERR_PARTIAL          - one-cycle pulse: partial word discarded
//   OVERFLOW             - one-cycle pulse: completed word dropped
module size_deconvert
  import size_deconvert_pkg::*;
#(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned LANES = 4
) (
  input  logic                  PCLK,
  input  logic                  RESET,
  input  logic [SIZE-1:0]       DATA_IN,
  input  logic                  VALID_IN,
  output logic [SIZE*LANES-1:0] DATA_OUT,
  output logic                  VALID_OUT,
  input  logic                  READY_IN,
  output logic                  IDLE_OUT,
  output logic                  ERR_PARTIAL,
  output logic                  OVERFLOW
);

  localparam int unsigned W  = SIZE * LANES;
  localparam int unsigned CW = cnt_width(LANES);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  if (!lanes_legal(LANES)) begin : g_lanes_check
    $error("size_deconvert: LANES must be 1, 2 or 4");
  end

  logic [0:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [W-1:0]  asm_q, asm_nx;
  logic          word_done;
  logic          err_nx;
  logic          err_q;

  // IDLE is only ever entered with cnt==0, so IDLE and FILL share the
  // "write lane cnt" path; the state only matters for the partial check.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    asm_nx    = asm_q;
    word_done = 1'b0;
    err_nx    = 1'b0;
    if (VALID_IN) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (cnt == CW'(k)) begin
          asm_nx[k*SIZE +: SIZE] = DATA_IN;
        end
      end
      state_nx = ST_FILL;
      if (cnt == LAST) begin
        word_done = 1'b1;
        cnt_nx    = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end else begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
      if ((state == ST_FILL) && (cnt != '0)) begin
        err_nx = 1'b1;
        asm_nx = '0;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
      asm_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      asm_q <= asm_nx;
      err_q <= err_nx;
    end
  end

  assign IDLE_OUT    = (state == ST_IDLE);
  assign ERR_PARTIAL = err_q;

  // asm_nx already contains the byte completing the word this cycle
  deconvert_out_reg #(
    .W(W)
  ) u_out_reg (
    .clk     (PCLK),
    .reset   (RESET),
    .load    (word_done),
    .word    (asm_nx),
    .ready   (READY_IN),
    .data    (DATA_OUT),
    .valid   (VALID_OUT),
    .overflow(OVERFLOW)
  );

endmodule

// File: doc/size_deconvert.md
SIZE_DECONVERT -- requirements
Module: size_deconvert

Interface
REQ-001 SHALL have parameter SIZE, default 8, meaning byte lane width in bits.
REQ-002 SHALL have parameter LANES, default 4, meaning bytes per output word; legal values 1, 2, 4 only.
REQ-003 SHALL have port PCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port DATA_IN  input  SIZE  incoming byte.
REQ-006 SHALL have port VALID_IN  input  1  DATA_IN qualifier; no backpressure toward the byte source.
REQ-007 SHALL have port DATA_OUT  output  SIZE*LANES  assembled word.
REQ-008 SHALL have port VALID_OUT  output  1  DATA_OUT holds a complete word.
REQ-009 SHALL have port READY_IN  input  1  downstream accepts word when VALID_OUT & READY_IN.
REQ-010 SHALL have port IDLE_OUT  output  1  high while FSM is in IDLE.
REQ-011 SHALL have port ERR_PARTIAL  output  1  one-cycle pulse: partial word discarded.
REQ-012 SHALL have port OVERFLOW  output  1  one-cycle pulse: completed word dropped.

Function
REQ-013 SHALL implement FSM states IDLE and FILL plus lane counter CNT (0..LANES-1).
REQ-014 IDLE: on VALID_IN=1 SHALL write DATA_IN to lane 0, set CNT=1, go FILL; if LANES=1 word completes that cycle and CNT=0.
REQ-015 FILL, VALID_IN=1: SHALL write DATA_IN to lane CNT; CNT==LANES-1 -> word complete, CNT wraps to 0, stay FILL; else CNT+1.
REQ-016 FILL, VALID_IN=0, CNT=0: SHALL go IDLE with no error.
REQ-017 FILL, VALID_IN=0, CNT!=0: SHALL discard assembly buffer, pulse ERR_PARTIAL next cycle, CNT=0, go IDLE.
REQ-018 Byte order SHALL be first-received byte in DATA_OUT[SIZE-1:0], lane k in DATA_OUT[(k+1)*SIZE-1:k*SIZE].
REQ-019 Latency: last byte sampled at edge N SHALL give VALID_OUT=1 with the word after edge N (visible cycle N+1), when output register free.
REQ-020 Output register SHALL be single entry, separate from assembly buffer, so assembly continues while a word waits.
REQ-021 On word complete, output register SHALL load if VALID_OUT=0 or (VALID_OUT & READY_IN) same cycle.
REQ-022 On word complete with VALID_OUT=1 and READY_IN=0 SHALL drop new word, keep held word, pulse OVERFLOW next cycle.
REQ-023 VALID_OUT SHALL clear after handshake unless reloaded same cycle; DATA_OUT SHALL stay stable while VALID_OUT=1 and READY_IN=0.
REQ-024 DATA_OUT SHALL retain last value when VALID_OUT=0 (no zeroing).
REQ-025 ERR_PARTIAL and OVERFLOW SHALL never exceed one cycle per event.

Reset
REQ-026 RESET=1 at edge SHALL force IDLE, CNT=0, DATA_OUT=0, VALID_OUT=0, IDLE_OUT=1, ERR_PARTIAL=0, OVERFLOW=0.
REQ-027 RESET SHALL override VALID_IN and READY_IN same cycle; reset mid-word SHALL discard silently (no ERR_PARTIAL).
REQ-028 First byte SHALL be accepted on the first edge with RESET=0.

Structure
REQ-029 FSM state encoding and LANES legality check SHALL live in a shared include file used with size_convert.
REQ-030 Output holding register with handshake SHALL be one sub-module, deconvert_out_reg.
REQ-031 Target size 120-400 lines RTL; no memories, no second clock.

Verification
REQ-032 LANES=4, VALID_IN high 4 cycles bytes 11,22,33,44, READY_IN=1 -> DATA_OUT=0x44332211, VALID_OUT one cycle, IDLE_OUT=0 then 1 after VALID_IN drops.
REQ-033 LANES=4, bytes AA,BB then VALID_IN=0 -> ERR_PARTIAL one pulse, no VALID_OUT, IDLE_OUT=1; next 4 bytes 01..04 -> 0x04030201.
REQ-034 LANES=2, 8 back-to-back bytes 01..08, READY_IN=0 -> DATA_OUT holds 0x0201, OVERFLOW pulses 3 times; READY_IN=1 -> handshake, VALID_OUT falls.
REQ-035 LANES=2, continuous bytes, READY_IN=1 -> words 0x0201, 0x0403, ... every 2 cycles, no OVERFLOW.
REQ-036 RESET asserted after 3rd byte of 4 -> all outputs reset values, no ERR_PARTIAL; next full word assembles correctly.
REQ-037 LANES=1, byte 5A -> DATA_OUT=0x5A, VALID_OUT next cycle.
